rr_arbiter: RTL and testbench

Round-robin arbiter that shares a single resource (e.g. a Counter instance or a shared datapath port) between REQUESTERS clients. Grants are held for as long as the winner keeps its request asserted, then priority rotates. One-hot grant plus an encoded index drive the downstream mux or enable.

---
 rtl/rr_arbiter.sv | 135 +++++++++++++
 tb/tb_rr_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants are held until the winner releases, then priority rotates past it.
// Define RR_ARBITER_TIMEOUT_EN to cap each grant at MAX_GRANT cycles with a timeout_o pulse.
module rr_arbiter #(
    parameter int unsigned REQUESTERS = 4,
    parameter int unsigned MAX_GRANT  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [REQUESTERS-1:0]         req_i,
    output logic [REQUESTERS-1:0]         gnt_o,
    output logic [$clog2(REQUESTERS)-1:0] gnt_idx_o,
    output logic                          busy_o,
    output logic                          timeout_o
);
    localparam int unsigned IDX_W = $clog2(REQUESTERS);

    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic {IDLE, GRANT} state_e;

    if (REQUESTERS < 2 || MAX_GRANT < 2) begin : g_param_check
        $error("rr_arbiter: REQUESTERS and MAX_GRANT must both be at least 2");
    end

    state_e                  state_q, state_d;
    logic [REQUESTERS-1:0]   gnt_q, gnt_d;
    idx_t                    idx_q, idx_d;
    idx_t                    ptr_q, ptr_d;
    logic                    busy_q, busy_d;
    logic                    win_vld;
    idx_t                    win_idx;
    idx_t                    cand;
    idx_t                    next_ptr;
    logic                    limit_hit;

`ifdef RR_ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_GRANT);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    assign limit_hit = (cnt_q == CNT_W'(MAX_GRANT - 1));
    assign timeout_o = timeout_q;
`else
    assign limit_hit = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Wrap by compare-and-clear so non-power-of-two counts never reach unused indices.
    assign next_ptr = (idx_q == idx_t'(REQUESTERS - 1)) ? '0 : idx_q + idx_t'(1);

    // First set request scanning ptr, ptr+1, ... with wrap back to 0.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = ptr_q;
        for (int k = 0; k < REQUESTERS; k++) begin
            if (!win_vld && req_i[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
            cand = (cand == idx_t'(REQUESTERS - 1)) ? '0 : cand + idx_t'(1);
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
`ifdef RR_ARBITER_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = GRANT;
                    gnt_d   = REQUESTERS'(1) << win_idx;
                    idx_d   = win_idx;
                    busy_d  = 1'b1;
`ifdef RR_ARBITER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
                if (!req_i[idx_q] || limit_hit) begin
                    // Dropping to IDLE here creates the one-cycle bubble between grants.
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = next_ptr;
`ifdef RR_ARBITER_TIMEOUT_EN
                    timeout_d = req_i[idx_q];
`endif
                end else begin
`ifdef RR_ARBITER_TIMEOUT_EN
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
`ifdef RR_ARBITER_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
`ifdef RR_ARBITER_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_idx_o = idx_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: a 4-requester and a 3-requester instance run side by side against
// a cycle-level reference model, with directed scenarios followed by random traffic.
module tb_rr_arbiter;
    localparam int MAXG = 4;
`ifdef RR_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] req4;
    logic [2:0] req3;
    logic [3:0] gnt4;
    logic [1:0] idx4;
    logic       busy4, to4;
    logic [2:0] gnt3;
    logic [1:0] idx3;
    logic       busy3, to3;

    always #5 clk_i = ~clk_i;

    rr_arbiter #(.REQUESTERS(4), .MAX_GRANT(MAXG)) u_dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req4), .gnt_o(gnt4),
        .gnt_idx_o(idx4), .busy_o(busy4), .timeout_o(to4)
    );

    rr_arbiter #(.REQUESTERS(3), .MAX_GRANT(MAXG)) u_dut3 (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req3), .gnt_o(gnt3),
        .gnt_idx_o(idx3), .busy_o(busy3), .timeout_o(to3)
    );

    int checks = 0;
    int errors = 0;

    // Reference model, one slot per instance: owner is -1 when nobody holds the resource.
    int owner [2];
    int ptr   [2];
    int len   [2];
    int last  [2];
    int tmo   [2];

    int  q4[$];
    int  q3[$];
    logic prev_busy4 = 1'b0;
    logic prev_busy3 = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input int u, input int n, input logic [3:0] req);
        if (rst_i) begin
            owner[u] = -1; ptr[u] = 0; len[u] = 0; last[u] = 0; tmo[u] = 0;
        end else if (owner[u] < 0) begin
            tmo[u] = 0;
            for (int k = 0; k < n; k++) begin
                int c = (ptr[u] + k) % n;
                if (req[c]) begin
                    owner[u] = c; last[u] = c; len[u] = 1;
                    break;
                end
            end
        end else if (!req[owner[u]]) begin
            ptr[u] = (owner[u] + 1) % n; owner[u] = -1; tmo[u] = 0;
        end else if (TO_EN && len[u] == MAXG) begin
            ptr[u] = (owner[u] + 1) % n; owner[u] = -1; tmo[u] = 1;
        end else begin
            len[u]++; tmo[u] = 0;
        end
    endtask

    function automatic logic [31:0] exp_gnt(input int u);
        return (owner[u] >= 0) ? (32'd1 << owner[u]) : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        model_edge(0, 4, req4);
        model_edge(1, 3, {1'b0, req3});
        #1;
        check("gnt4",  32'(gnt4),  exp_gnt(0));
        check("idx4",  32'(idx4),  32'(last[0]));
        check("busy4", 32'(busy4), 32'(owner[0] >= 0));
        check("to4",   32'(to4),   32'(tmo[0]));
        check("gnt3",  32'(gnt3),  exp_gnt(1));
        check("idx3",  32'(idx3),  32'(last[1]));
        check("busy3", 32'(busy3), 32'(owner[1] >= 0));
        check("to3",   32'(to3),   32'(tmo[1]));
        if (busy4 && !prev_busy4) q4.push_back(int'(idx4));
        if (busy3 && !prev_busy3) q3.push_back(int'(idx3));
        prev_busy4 = busy4;
        prev_busy3 = busy3;
    endtask

    initial begin
        int exp_order4[5];
        int exp_order3[5];
        exp_order4 = '{0, 1, 2, 3, 0};
        exp_order3 = '{0, 1, 2, 0, 1};
        for (int u = 0; u < 2; u++) begin
            owner[u] = -1; ptr[u] = 0; len[u] = 0; last[u] = 0; tmo[u] = 0;
        end

        // Reset held with all requests up, then the first grant goes to client 0.
        rst_i = 1'b1; req4 = 4'b1111; req3 = 3'b111;
        tick(); tick();
        rst_i = 1'b0;
        tick();
        check("post_reset_gnt4", 32'(gnt4), 32'h1);

        // Single request from client 2 held, then released; ptr moves to 3.
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        req4 = 4'b0100; req3 = 3'b000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_gnt4", 32'(gnt4), 32'h4);
        end
        req4 = 4'b0000;
        tick();
        check("bubble_gnt4", 32'(gnt4), 32'h0);
        req4 = 4'b1001;
        tick();
        check("ptr3_idx4", 32'(idx4), 32'd3);

        // All requesting; each winner lets go after 2 (4-way) or 1 (3-way) granted cycles.
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        q4.delete(); q3.delete();
        for (int i = 0; i < 20; i++) begin
            req4 = 4'b1111;
            req3 = 3'b111;
            if (owner[0] >= 0 && len[0] >= 2) req4[owner[0]] = 1'b0;
            if (owner[1] >= 0 && len[1] >= 1) req3[owner[1]] = 1'b0;
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            check("order4", (i < q4.size()) ? 32'(q4[i]) : 32'hFFFF_FFFF, 32'(exp_order4[i]));
            check("order3", (i < q3.size()) ? 32'(q3[i]) : 32'hFFFF_FFFF, 32'(exp_order3[i]));
        end

        // Two clients requesting continuously (grants are bounded only with the limit compiled in).
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        req4 = 4'b0011; req3 = 3'b011;
        for (int i = 0; i < 24; i++) tick();

        // Reset lands on the 3rd cycle of a grant to client 1; client 0 then wins.
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        req4 = 4'b0001; tick();
        req4 = 4'b0000; tick();
        req4 = 4'b0011; tick(); tick();
        check("pre_rst_idx4", 32'(idx4), 32'd1);
        rst_i = 1'b1; tick();
        check("rst_mid_gnt4", 32'(gnt4), 32'h0);
        rst_i = 1'b0; tick();
        check("after_rst_gnt4", 32'(gnt4), 32'h1);

        // Random traffic biased toward holders keeping their request, with rare resets.
        for (int i = 0; i < 400; i++) begin
            req4 = 4'($urandom);
            req3 = 3'($urandom);
            if (owner[0] >= 0 && $urandom_range(0, 7) != 0) req4[owner[0]] = 1'b1;
            if (owner[1] >= 0 && $urandom_range(0, 7) != 0) req3[owner[1]] = 1'b1;
            rst_i = ($urandom_range(0, 63) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
